// File: rtl/bram_mrp_pkg.sv
// ============================================================================
// Module   : bram_mrp_pkg
// Brief    : Shared types and byte helpers for the bram_mrp memory.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bram_mrp_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } bram_state_e;

    localparam int BYTE_W = 8;

    function automatic logic [BYTE_W-1:0] be_merge_byte(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              en
    );
        return en ? new_byte : old_byte;
    endfunction

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_mrp_rdport.sv
// ============================================================================
// Module   : bram_mrp_rdport
// Brief    : One read port: write-first bypass, data register, optional
//            second pipeline stage, valid tracking (parity: BRAM_MRP_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bram_mrp_rdport
    import bram_mrp_pkg::*;
#(
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int RD_LATENCY      = 1,
    parameter int WRITE_FIRST     = 1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              rd_en,
    input  logic [BRAM_DATA_WIDTH-1:0]        mem_word,
    input  logic                              wr_hit,
    input  logic [BRAM_DATA_WIDTH-1:0]        wr_word,
`ifdef BRAM_MRP_PARITY_EN
    input  logic [BRAM_DATA_WIDTH/BYTE_W-1:0] mem_par,
    input  logic [BRAM_DATA_WIDTH/BYTE_W-1:0] wr_par,
    output logic                              par_err,
`endif
    output logic [BRAM_DATA_WIDTH-1:0]        dout,
    output logic                              rd_valid
);

    logic                       w_bypass;
    logic [BRAM_DATA_WIDTH-1:0] w_word;
    logic                       r_v1;
    logic [BRAM_DATA_WIDTH-1:0] r_d1;

    // mem_word is the pre-edge contents, so read-first falls out naturally.
    always_comb begin
        w_bypass = (WRITE_FIRST != 0) && wr_hit;
        w_word   = w_bypass ? wr_word : mem_word;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= rd_en;
            if (rd_en) r_d1 <= w_word;
        end
    end

`ifdef BRAM_MRP_PARITY_EN
    logic [BRAM_DATA_WIDTH/BYTE_W-1:0] w_par_calc;
    logic [BRAM_DATA_WIDTH/BYTE_W-1:0] w_par_sel;
    logic                              r_e1;

    always_comb begin
        w_par_calc = '0;
        for (int i = 0; i < BRAM_DATA_WIDTH/BYTE_W; i++)
            w_par_calc[i] = byte_parity(w_word[i*BYTE_W +: BYTE_W]);
        w_par_sel = w_bypass ? wr_par : mem_par;
    end

    always_ff @(posedge clock) begin
        if (!reset_n)   r_e1 <= 1'b0;
        else if (rd_en) r_e1 <= |(w_par_calc ^ w_par_sel);
    end
`endif

    if (RD_LATENCY == 2) begin : g_lat2
        logic                       r_v2;
        logic [BRAM_DATA_WIDTH-1:0] r_d2;

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) r_d2 <= r_d1;
            end
        end

        assign dout     = r_d2;
        assign rd_valid = r_v2;

`ifdef BRAM_MRP_PARITY_EN
        logic r_e2;
        always_ff @(posedge clock) begin
            if (!reset_n)  r_e2 <= 1'b0;
            else if (r_v1) r_e2 <= r_e1;
        end
        assign par_err = r_v2 & r_e2;
`endif
    end else begin : g_lat1
        assign dout     = r_d1;
        assign rd_valid = r_v1;
`ifdef BRAM_MRP_PARITY_EN
        assign par_err  = r_v1 & r_e1;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/bram_mrp.sv
// ============================================================================
// Module   : bram_mrp
// Brief    : Multi-read-port RAM with byte-enable writes and a clear engine.
//            Optional per-byte parity: define BRAM_MRP_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bram_mrp
    import bram_mrp_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 6,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int NUM_RD          = 2,
    parameter int RD_LATENCY      = 1,
    parameter int WRITE_FIRST     = 1,
    parameter int CLEAR_ON_RESET  = 1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              clr_req,
    output logic                              busy,
    input  logic                              wr_en,
    input  logic [BRAM_ADDR_WIDTH-1:0]        wr_addr,
    input  logic [BRAM_DATA_WIDTH/BYTE_W-1:0] wr_be,
    input  logic [BRAM_DATA_WIDTH-1:0]        din,
`ifdef BRAM_MRP_PARITY_EN
    input  logic                              par_inj,
    output logic [NUM_RD-1:0]                 par_err,
`endif
    input  logic [NUM_RD-1:0]                 rd_en,
    input  logic [NUM_RD*BRAM_ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*BRAM_DATA_WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]                 rd_valid
);

    localparam int c_DEPTH = 2**BRAM_ADDR_WIDTH;
    localparam int c_NB    = BRAM_DATA_WIDTH / BYTE_W;

    logic [BRAM_DATA_WIDTH-1:0] r_mem [c_DEPTH];
    bram_state_e                r_state;
    bram_state_e                w_state_nxt;
    logic [BRAM_ADDR_WIDTH-1:0] r_cnt;
    logic                       w_wr_active;
    logic [BRAM_DATA_WIDTH-1:0] w_wr_old;
    logic [BRAM_DATA_WIDTH-1:0] w_wr_word;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clr_req) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_cnt == '1) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state == ST_CLEAR);
        w_wr_active = wr_en & ~busy;
    end

    // The merged word feeds both the array and the write-first bypass.
    always_comb begin
        w_wr_old  = r_mem[wr_addr];
        w_wr_word = w_wr_old;
        for (int i = 0; i < c_NB; i++)
            w_wr_word[i*BYTE_W +: BYTE_W] = be_merge_byte(w_wr_old[i*BYTE_W +: BYTE_W],
                                                          din[i*BYTE_W +: BYTE_W], wr_be[i]);
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (busy)             r_mem[r_cnt]   <= '0;
            else if (w_wr_active) r_mem[wr_addr] <= w_wr_word;
        end
    end

`ifdef BRAM_MRP_PARITY_EN
    logic [c_NB-1:0] r_par [c_DEPTH];
    logic [c_NB-1:0] w_wr_par;

    always_comb begin
        w_wr_par = r_par[wr_addr];
        for (int i = 0; i < c_NB; i++)
            if (wr_be[i]) w_wr_par[i] = byte_parity(din[i*BYTE_W +: BYTE_W]) ^ par_inj;
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (busy)             r_par[r_cnt]   <= '0;
            else if (w_wr_active) r_par[wr_addr] <= w_wr_par;
        end
    end
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [BRAM_ADDR_WIDTH-1:0] w_rd_addr;
        logic                       w_hit;
        logic                       w_en;

        assign w_rd_addr = rd_addr[p*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
        assign w_hit     = w_wr_active && (wr_addr == w_rd_addr);
        assign w_en      = rd_en[p] & ~busy;

        bram_mrp_rdport #(
            .BRAM_DATA_WIDTH (BRAM_DATA_WIDTH),
            .RD_LATENCY      (RD_LATENCY),
            .WRITE_FIRST     (WRITE_FIRST)
        ) u_rdport (
            .clock    (clock),
            .reset_n  (reset_n),
            .rd_en    (w_en),
            .mem_word (r_mem[w_rd_addr]),
            .wr_hit   (w_hit),
            .wr_word  (w_wr_word),
`ifdef BRAM_MRP_PARITY_EN
            .mem_par  (r_par[w_rd_addr]),
            .wr_par   (w_wr_par),
            .par_err  (par_err[p]),
`endif
            .dout     (dout[p*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH]),
            .rd_valid (rd_valid[p])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_bram_mrp.sv
// ============================================================================
// Module   : tb_bram_mrp
// Brief    : Directed bench; DUT A is the default build, DUT B uses
//            RD_LATENCY=2 / WRITE_FIRST=0. Parity steps under BRAM_MRP_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bram_mrp;

    logic        clock;
    logic        reset_n;
    logic        clr_req;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] din;
    logic [1:0]  rd_en;
    logic [11:0] rd_addr;
    logic        busy_a, busy_b;
    logic [63:0] dout_a, dout_b;
    logic [1:0]  rd_valid_a, rd_valid_b;
`ifdef BRAM_MRP_PARITY_EN
    logic        par_inj;
    logic [1:0]  par_err_a, par_err_b;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    bram_mrp dut_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .busy     (busy_a),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .din      (din),
`ifdef BRAM_MRP_PARITY_EN
        .par_inj  (par_inj),
        .par_err  (par_err_a),
`endif
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .dout     (dout_a),
        .rd_valid (rd_valid_a)
    );

    bram_mrp #(.RD_LATENCY(2), .WRITE_FIRST(0)) dut_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .busy     (busy_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .din      (din),
`ifdef BRAM_MRP_PARITY_EN
        .par_inj  (par_inj),
        .par_err  (par_err_b),
`endif
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .dout     (dout_b),
        .rd_valid (rd_valid_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_be = '0; din = '0; rd_en = '0; rd_addr = '0;
`ifdef BRAM_MRP_PARITY_EN
        par_inj = 1'b0;
`endif
        tick(); tick();
        chk("rst_busy", busy_a, 1);
        chk("rst_valid", {rd_valid_b, rd_valid_a}, 0);
        chk("rst_dout", dout_a, 0);

        // Power-up clear must last exactly DEPTH cycles.
        reset_n = 1'b1;
        n = 0;
        while (busy_a && n < 200) begin tick(); n++; end
        chk("clr_len_reset", n, 64);
        chk("busy_b_done", busy_b, 0);

        rd_en = 2'b01; rd_addr = {6'd0, 6'd63}; tick(); rd_en = 2'b00;
        chk("rd63_a_valid", rd_valid_a, 2'b01);
        chk("rd63_a_data", dout_a[31:0], 0);
        chk("rd63_b_early", rd_valid_b, 2'b00);
        tick();
        chk("rd63_b_valid", rd_valid_b, 2'b01);
        chk("rd63_a_drop", rd_valid_a, 2'b00);

        // Byte-enable merge, both ports reading the same word.
        wr_en = 1'b1; wr_addr = 6'd5; wr_be = 4'hF; din = 32'hDEADBEEF; tick();
        wr_be = 4'h1; din = 32'h000000AA; tick(); wr_en = 1'b0;
        rd_en = 2'b11; rd_addr = {6'd5, 6'd5}; tick(); rd_en = 2'b00;
        chk("wr5_a_data", dout_a, {2{32'hDEADBEAA}});
        chk("wr5_a_valid", rd_valid_a, 2'b11);
        tick();
        chk("wr5_b_data", dout_b, {2{32'hDEADBEAA}});
        chk("wr5_b_valid", rd_valid_b, 2'b11);
        chk("idle_a_valid", rd_valid_a, 2'b00);
        chk("idle_a_hold", dout_a, {2{32'hDEADBEAA}});

        // Read-during-write: full word, then a partial-byte write.
        wr_en = 1'b1; wr_addr = 6'd9; wr_be = 4'hF; din = 32'hCAFEF00D; tick();
        din = 32'h12345678; rd_en = 2'b01; rd_addr = {6'd0, 6'd9}; tick();
        chk("rdw_a", dout_a[31:0], 32'h12345678);
        din = 32'hFFFFFFFF; wr_be = 4'b0011; tick(); wr_en = 1'b0; rd_en = 2'b00;
        chk("rdw_part_a", dout_a[31:0], 32'h1234FFFF);
        chk("rdw_b", dout_b[31:0], 32'hCAFEF00D);
        tick();
        chk("rdw_part_b", dout_b[31:0], 32'h12345678);

        // Back-to-back reads through both latencies.
        wr_en = 1'b1; wr_be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            wr_addr = 6'(i); din = 32'(17 * (i + 1)); tick();
        end
        wr_en = 1'b0;
        rd_en = 2'b01; rd_addr = {6'd0, 6'd0}; tick();
        chk("pipe_a0", dout_a[31:0], 32'h11);
        rd_addr = {6'd0, 6'd1}; tick();
        chk("pipe_a1", dout_a[31:0], 32'h22);
        chk("pipe_b0", {30'd0, rd_valid_b, dout_b[31:0]}, {32'd1, 32'h11});
        rd_addr = {6'd0, 6'd2}; tick();
        chk("pipe_a2", dout_a[31:0], 32'h33);
        chk("pipe_b1", {30'd0, rd_valid_b, dout_b[31:0]}, {32'd1, 32'h22});
        rd_en = 2'b00; tick();
        chk("pipe_a_off", rd_valid_a, 2'b00);
        chk("pipe_b2", {30'd0, rd_valid_b, dout_b[31:0]}, {32'd1, 32'h33});
        tick();
        chk("pipe_b_off", {30'd0, rd_valid_b, dout_b[31:0]}, {32'd0, 32'h33});

        // Requested clear: traffic during busy is ignored, second request too.
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        chk("clr_busy_rise", busy_a, 1);
        wr_en = 1'b1; wr_addr = 6'd5; wr_be = 4'hF; din = 32'hFFFFFFFF;
        rd_en = 2'b11; rd_addr = {6'd9, 6'd5}; tick(); wr_en = 1'b0; rd_en = 2'b00;
        chk("busy_no_valid", {rd_valid_b, rd_valid_a}, 0);
        chk("busy_hold_a", dout_a, {32'hDEADBEAA, 32'h00000033});
        chk("busy_hold_b", dout_b, {32'hDEADBEAA, 32'h00000033});
        n = 2;
        while (busy_a && n < 200) begin
            clr_req = (n == 10);
            tick();
            if (busy_a) n++;
        end
        clr_req = 1'b0;
        chk("clr_len_req", n, 64);

        for (int i = 0; i < 64; i++) begin
            rd_en = 2'b11; rd_addr = {6'(63 - i), 6'(i)}; tick();
            chk("sweep_data", dout_a, 0);
            chk("sweep_valid", rd_valid_a, 2'b11);
        end
        rd_en = 2'b00; tick();

        // Reset at clear address 20 restarts the full clear.
        wr_en = 1'b1; wr_addr = 6'd40; wr_be = 4'hF; din = 32'hA5A5A5A5; tick(); wr_en = 1'b0;
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        repeat (20) tick();
        chk("mid_clr_busy", busy_a, 1);
        reset_n = 1'b0; tick();
        chk("mid_rst_busy", busy_a, 1);
        reset_n = 1'b1;
        n = 0;
        while (busy_a && n < 200) begin tick(); n++; end
        chk("clr_len_restart", n, 64);
        rd_en = 2'b10; rd_addr = {6'd40, 6'd0}; tick(); rd_en = 2'b00;
        chk("rd40_cleared", {30'd0, rd_valid_a, dout_a[63:32]}, {32'd2, 32'h0});

        // wr_be of zero leaves the word untouched.
        wr_en = 1'b1; wr_addr = 6'd7; wr_be = 4'hF; din = 32'h00000001; tick();
        wr_be = 4'h0; din = 32'hFFFFFFFF; tick(); wr_en = 1'b0;
        rd_en = 2'b01; rd_addr = {6'd0, 6'd7}; tick(); rd_en = 2'b00;
        chk("be_zero", dout_a[31:0], 32'h00000001);

`ifdef BRAM_MRP_PARITY_EN
        wr_en = 1'b1; wr_be = 4'hF; din = 32'h01020304;
        wr_addr = 6'd3; par_inj = 1'b1; tick();
        wr_addr = 6'd4; par_inj = 1'b0; tick(); wr_en = 1'b0;
        rd_en = 2'b11; rd_addr = {6'd4, 6'd3}; tick(); rd_en = 2'b00;
        chk("par_err_a", par_err_a, 2'b01);
        tick();
        chk("par_err_b", par_err_b, 2'b01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
